fetch_sequencer: RTL and testbench

- Parametrised successor to the processor's inline PC-advance logic, and the program-counter and fetch-control block of the 5-stage pipeline.
- Owns the PC and the halt ("done") detection.
- Arbitrates EX-stage branch redirects against hazard stalls.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so taken branches are predicted in IF. Mispredictions are recovered at EX via a flush.

---
 rtl/pipe_pkg.sv | 41 ++++
 rtl/fetch_sequencer_if.sv | 39 +++
 rtl/btb.sv | 91 +++++++++
 rtl/fetch_sequencer.sv | 96 +++++++++
 tb/tb_fetch_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg - shared types for the fetch sequencer and its branch target buffer.
//   pc_t        : program-counter word (PC_W bits)
//   btb_entry_t : one BTB line {valid, tag, target, ctr}
//   CTR_*       : 2-bit saturating counter encodings used at reset/allocate
//   ctr_inc/dec : saturating counter helpers
// Modules may be built with a PC width up to PC_W; narrower widths are
// zero-extended into the struct fields.
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int PC_W = 6;

    typedef logic [PC_W-1:0] pc_t;

    localparam logic [1:0] CTR_WEAK_NT = 2'b01;
    localparam logic [1:0] CTR_WEAK_T  = 2'b10;

    typedef struct packed {
        logic       valid;
        pc_t        tag;
        pc_t        target;
        logic [1:0] ctr;
    } btb_entry_t;

    localparam btb_entry_t BTB_ENTRY_RESET = '{
        valid:  1'b0,
        tag:    '0,
        target: '0,
        ctr:    CTR_WEAK_NT
    };

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_if - hazard/EX inputs and IF outputs of the fetch sequencer.
//   master : hazard unit / EX stage side (drives stall and resolved branch)
//   slave  : fetch_sequencer side (drives imem_addr, IF prediction, flush, done)
// ---------------------------------------------------------------------------
interface fetch_sequencer_if #(
    parameter int PC_WIDTH   = 6,
    parameter int IMEM_DEPTH = 32
);
    localparam int AW = $clog2(IMEM_DEPTH);

    logic                stall;
    logic                ex_branch_valid;
    logic [PC_WIDTH-1:0] ex_pc;
    logic                ex_taken;
    logic [PC_WIDTH-1:0] ex_target;
    logic                ex_pred_taken;
    logic [PC_WIDTH-1:0] ex_pred_target;

    logic [AW-1:0]       imem_addr;
    logic [PC_WIDTH-1:0] if_pc;
    logic                if_pred_taken;
    logic [PC_WIDTH-1:0] if_pred_target;
    logic                flush;
    logic                done;

    modport master (
        output stall, ex_branch_valid, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        input  imem_addr, if_pc, if_pred_taken, if_pred_target, flush, done
    );

    modport slave (
        input  stall, ex_branch_valid, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        output imem_addr, if_pc, if_pred_taken, if_pred_target, flush, done
    );

endinterface

// File: rtl/btb.sv
// ---------------------------------------------------------------------------
// btb - direct-mapped branch target buffer with 2-bit saturating counters.
//   clk, rst_n   : clock / async active-low reset (clears all entries)
//   rd_pc        : lookup address (combinational port)
//   rd_hit       : valid entry with matching tag
//   rd_ctr       : counter of the indexed entry
//   rd_target    : stored target of the indexed entry
//   wr_en        : resolved branch update this cycle
//   wr_pc        : PC of the resolved branch
//   wr_taken     : resolved outcome
//   wr_target    : resolved target
// The read port always returns the pre-edge contents, so a lookup of the line
// being written in the same cycle sees the old entry.
// ---------------------------------------------------------------------------
module btb
    import pipe_pkg::*;
#(
    parameter int BTB_ENTRIES = 4,
    parameter int PC_WIDTH    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PC_WIDTH-1:0] rd_pc,
    output logic                rd_hit,
    output logic [1:0]          rd_ctr,
    output logic [PC_WIDTH-1:0] rd_target,
    input  logic                wr_en,
    input  logic [PC_WIDTH-1:0] wr_pc,
    input  logic                wr_taken,
    input  logic [PC_WIDTH-1:0] wr_target
);

    localparam int IDX = $clog2(BTB_ENTRIES);

    btb_entry_t [BTB_ENTRIES-1:0] entry_q;
    btb_entry_t [BTB_ENTRIES-1:0] entry_d;

    logic [IDX-1:0] rd_idx;
    logic [IDX-1:0] wr_idx;
    pc_t            rd_tag;
    pc_t            wr_tag;
    btb_entry_t     rd_entry;
    btb_entry_t     wr_entry;
    logic           wr_hit;

    // Tag is the PC with the index bits shifted out.
    assign rd_idx   = rd_pc[IDX-1:0];
    assign rd_tag   = pc_t'(rd_pc >> IDX);
    assign rd_entry = entry_q[rd_idx];

    assign rd_hit    = rd_entry.valid && (rd_entry.tag == rd_tag);
    assign rd_ctr    = rd_entry.ctr;
    assign rd_target = PC_WIDTH'(rd_entry.target);

    assign wr_idx   = wr_pc[IDX-1:0];
    assign wr_tag   = pc_t'(wr_pc >> IDX);
    assign wr_entry = entry_q[wr_idx];
    assign wr_hit   = wr_entry.valid && (wr_entry.tag == wr_tag);

    always_comb begin
        entry_d = entry_q;
        if (wr_en) begin
            if (wr_taken) begin
                if (wr_hit) begin
                    entry_d[wr_idx].ctr    = ctr_inc(wr_entry.ctr);
                    entry_d[wr_idx].target = pc_t'(wr_target);
                end else begin
                    // Allocation overwrites whatever aliased into this line.
                    entry_d[wr_idx] = '{
                        valid:  1'b1,
                        tag:    wr_tag,
                        target: pc_t'(wr_target),
                        ctr:    CTR_WEAK_T
                    };
                end
            end else if (wr_hit) begin
                // Not-taken only weakens a known branch; misses are left alone.
                entry_d[wr_idx].ctr = ctr_dec(wr_entry.ctr);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= {BTB_ENTRIES{BTB_ENTRY_RESET}};
        end else begin
            entry_q <= entry_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer - PC register, next-PC selection and halt detection for
// the 5-stage pipeline, with IF-stage branch prediction from a BTB.
//   clk, rst_n : clock / async active-low reset
//   bus.slave  : stall and EX branch resolution in; imem_addr, if_pc,
//                if_pred_taken/target, flush and done out
// Next-PC priority: EX mispredict redirect > stall hold > predicted taken
// target > sequential pc+1. PC arithmetic wraps silently.
// ---------------------------------------------------------------------------
module fetch_sequencer
    import pipe_pkg::*;
#(
    parameter int PC_WIDTH    = 6,
    parameter int IMEM_DEPTH  = 32,
    parameter int BTB_ENTRIES = 4,
    parameter int BTB_EN      = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_sequencer_if.slave bus
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                done_q, done_d;

    logic                btb_hit;
    logic [1:0]          btb_ctr;
    logic [PC_WIDTH-1:0] btb_target;

    logic                pred_taken;
    logic [PC_WIDTH-1:0] pred_target;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] fix_pc;
    logic                mispredict;

    btb #(
        .BTB_ENTRIES (BTB_ENTRIES),
        .PC_WIDTH    (PC_WIDTH)
    ) u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_pc     (pc_q),
        .rd_hit    (btb_hit),
        .rd_ctr    (btb_ctr),
        .rd_target (btb_target),
        .wr_en     ((BTB_EN != 0) && bus.ex_branch_valid),
        .wr_pc     (bus.ex_pc),
        .wr_taken  (bus.ex_taken),
        .wr_target (bus.ex_target)
    );

    assign pc_inc      = pc_q + PC_WIDTH'(1);
    assign pred_taken  = (BTB_EN != 0) && btb_hit && (btb_ctr >= 2'd2);
    assign pred_target = btb_hit ? btb_target : pc_inc;

    // A taken branch is also wrong when it went somewhere other than predicted.
    // EX inputs are meaningless while in reset, so the compare is gated off.
    assign mispredict = rst_n && bus.ex_branch_valid &&
                        ((bus.ex_taken != bus.ex_pred_taken) ||
                         (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));

    assign fix_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + PC_WIDTH'(1);

    always_comb begin
        pc_d = pc_inc;
        if (mispredict) begin
            pc_d = fix_pc;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
        // Looks at the current PC, so done lags the PC by one cycle.
        done_d = (32'(pc_q) >= 32'(IMEM_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= '0;
            done_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            done_q <= done_d;
        end
    end

    assign bus.imem_addr      = pc_q[AW-1:0];
    assign bus.if_pc          = pc_q;
    assign bus.if_pred_taken  = pred_taken;
    assign bus.if_pred_target = pred_target;
    assign bus.flush          = mispredict;
    assign bus.done           = done_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer - directed scenarios plus randomized traffic for
// fetch_sequencer. A reference model (integer PC, plain arrays for the BTB)
// tracks the predictor-enabled instance; a second instance is built with
// prediction disabled.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int PCW   = 6;
    localparam int DEPTH = 32;
    localparam int NE    = 4;
    localparam int PCMOD = 64;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.PC_WIDTH(PCW), .IMEM_DEPTH(DEPTH)) bus  ();
    fetch_sequencer_if #(.PC_WIDTH(PCW), .IMEM_DEPTH(DEPTH)) bus0 ();

    fetch_sequencer #(
        .PC_WIDTH(PCW), .IMEM_DEPTH(DEPTH), .BTB_ENTRIES(NE), .BTB_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    fetch_sequencer #(
        .PC_WIDTH(PCW), .IMEM_DEPTH(DEPTH), .BTB_ENTRIES(NE), .BTB_EN(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    int m_pc;
    bit m_done;
    bit m_valid [NE];
    int m_tag   [NE];
    int m_tgt   [NE];
    int m_ctr   [NE];

    function automatic void model_reset();
        m_pc   = 0;
        m_done = 0;
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
    endfunction

    function automatic bit m_hit(input int pc);
        return m_valid[pc % NE] && (m_tag[pc % NE] == pc / NE);
    endfunction

    function automatic bit m_pred_t(input int pc);
        return m_hit(pc) && (m_ctr[pc % NE] >= 2);
    endfunction

    function automatic int m_pred_tgt(input int pc);
        return m_hit(pc) ? m_tgt[pc % NE] : (pc + 1) % PCMOD;
    endfunction

    function automatic bit m_misp();
        return bus.ex_branch_valid &&
               ((bus.ex_taken != bus.ex_pred_taken) ||
                (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));
    endfunction

    // Advance one clock: compute the model's next state from the inputs as
    // they stand before the edge, then wait for the edge and commit.
    task automatic clk_step();
        int npc, i, xpc, xtgt;
        bit nd, h, bv, tk;
        bv   = bus.ex_branch_valid;
        tk   = bus.ex_taken;
        xpc  = int'(bus.ex_pc);
        xtgt = int'(bus.ex_target);
        if (m_misp())               npc = tk ? xtgt : (xpc + 1) % PCMOD;
        else if (bus.stall)         npc = m_pc;
        else if (m_pred_t(m_pc))    npc = m_pred_tgt(m_pc);
        else                        npc = (m_pc + 1) % PCMOD;
        nd = (m_pc >= DEPTH);
        i  = xpc % NE;
        h  = m_hit(xpc);
        @(posedge clk);
        m_pc   = npc;
        m_done = nd;
        if (bv) begin
            if (tk && h) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i] = xtgt;
            end else if (tk) begin
                m_valid[i] = 1; m_tag[i] = xpc / NE; m_tgt[i] = xtgt; m_ctr[i] = 2;
            end else if (h) begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end
        #1;
    endtask

    task automatic set_ex(input bit bv, input int pc, input bit tk, input int tgt,
                          input bit ptk, input int ptgt);
        bus.ex_branch_valid = bv;
        bus.ex_pc           = PCW'(pc);
        bus.ex_taken        = tk;
        bus.ex_target       = PCW'(tgt);
        bus.ex_pred_taken   = ptk;
        bus.ex_pred_target  = PCW'(ptgt);
    endtask

    task automatic clear_ex();
        set_ex(0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_ex0(input bit bv, input int pc, input bit tk, input int tgt,
                           input bit ptk, input int ptgt);
        bus0.ex_branch_valid = bv;
        bus0.ex_pc           = PCW'(pc);
        bus0.ex_taken        = tk;
        bus0.ex_target       = PCW'(tgt);
        bus0.ex_pred_taken   = ptk;
        bus0.ex_pred_target  = PCW'(ptgt);
    endtask

    // Called just after an edge; releases reset well before the next one.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_ex();
        set_ex0(0, 0, 0, 0, 0, 0);
        bus.stall  = 1'b0;
        bus0.stall = 1'b0;
        #2;
        model_reset();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic run_to(input int target);
        int n = 0;
        while (m_pc != target && n < 80) begin
            clk_step();
            n++;
        end
        n_checks++;
        if (m_pc != target) begin
            n_errors++;
            $display("FAIL run_to_timeout pc %0d wanted %0d", m_pc, target);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus0.stall = 1'b0;
        set_ex0(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        // A would-be mispredict while in reset must not flush.
        set_ex(1, 3, 1, 9, 0, 4);
        #2;
        n_checks++; if (bus.if_pc !== 6'd0) begin n_errors++; $display("FAIL reset_pc got %0d exp 0", bus.if_pc); end
        n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        n_checks++; if (bus.flush !== 1'b0) begin n_errors++; $display("FAIL reset_flush got %b exp 0", bus.flush); end
        n_checks++; if (bus.if_pred_taken !== 1'b0) begin n_errors++; $display("FAIL reset_pred got %b exp 0", bus.if_pred_taken); end
        @(posedge clk); #1;
        do_reset();
    endtask

    task automatic test_straight_line();
        for (int k = 0; k < 36; k++) begin
            n_checks++;
            if (bus.if_pc !== 6'(k)) begin n_errors++; $display("FAIL straight_pc got %0d exp %0d", bus.if_pc, k); end
            n_checks++;
            if (bus.imem_addr !== 5'(k % 32)) begin n_errors++; $display("FAIL straight_addr got %0d exp %0d", bus.imem_addr, k % 32); end
            n_checks++;
            if (bus.done !== (k >= 33)) begin n_errors++; $display("FAIL straight_done at %0d got %b exp %b", k, bus.done, k >= 33); end
            clk_step();
        end
    endtask

    task automatic test_stall_redirect();
        do_reset();
        run_to(5);
        bus.stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            clk_step();
            n_checks++;
            if (bus.if_pc !== 6'd5) begin n_errors++; $display("FAIL stall_hold got %0d exp 5", bus.if_pc); end
        end
        set_ex(1, 3, 1, 10, 0, 4);
        #1;
        n_checks++; if (bus.flush !== 1'b1) begin n_errors++; $display("FAIL stall_redir_flush got %b exp 1", bus.flush); end
        clk_step();
        clear_ex();
        bus.stall = 1'b0;
        n_checks++; if (bus.if_pc !== 6'd10) begin n_errors++; $display("FAIL stall_redir_pc got %0d exp 10", bus.if_pc); end
    endtask

    task automatic test_cold_learn();
        do_reset();
        run_to(7);
        #1;
        n_checks++; if (bus.if_pred_taken !== 1'b0) begin n_errors++; $display("FAIL cold_pred got %b exp 0", bus.if_pred_taken); end
        clk_step();
        set_ex(1, 7, 1, 2, 0, 8);
        #1;
        n_checks++; if (bus.flush !== 1'b1) begin n_errors++; $display("FAIL cold_flush got %b exp 1", bus.flush); end
        clk_step();
        clear_ex();
        n_checks++; if (bus.if_pc !== 6'd2) begin n_errors++; $display("FAIL cold_redir got %0d exp 2", bus.if_pc); end
        run_to(7);
        #1;
        n_checks++; if (bus.if_pred_taken !== 1'b1) begin n_errors++; $display("FAIL learn_pred got %b exp 1", bus.if_pred_taken); end
        n_checks++; if (bus.if_pred_target !== 6'd2) begin n_errors++; $display("FAIL learn_tgt got %0d exp 2", bus.if_pred_target); end
        clk_step();
        n_checks++; if (bus.if_pc !== 6'd2) begin n_errors++; $display("FAIL learn_pc got %0d exp 2", bus.if_pc); end
        set_ex(1, 7, 1, 2, 1, 2);
        #1;
        n_checks++; if (bus.flush !== 1'b0) begin n_errors++; $display("FAIL learn_noflush got %b exp 0", bus.flush); end
        clk_step();
        clear_ex();
        n_checks++; if (bus.if_pc !== 6'd3) begin n_errors++; $display("FAIL learn_seq got %0d exp 3", bus.if_pc); end
    endtask

    // Runs straight after test_cold_learn: the line for pc=7 is at ctr=3.
    task automatic test_hysteresis();
        run_to(7);
        #1;
        n_checks++; if (bus.if_pred_taken !== 1'b1) begin n_errors++; $display("FAIL hyst_c3 got %b exp 1", bus.if_pred_taken); end
        clk_step();
        set_ex(1, 7, 0, 2, 1, 2);
        #1;
        n_checks++; if (bus.flush !== 1'b1) begin n_errors++; $display("FAIL hyst_flush1 got %b exp 1", bus.flush); end
        clk_step();
        clear_ex();
        n_checks++; if (bus.if_pc !== 6'd8) begin n_errors++; $display("FAIL hyst_fix1 got %0d exp 8", bus.if_pc); end
        set_ex(1, 20, 1, 7, 0, 21);
        clk_step();
        clear_ex();
        #1;
        n_checks++; if (bus.if_pred_taken !== 1'b1) begin n_errors++; $display("FAIL hyst_c2 got %b exp 1", bus.if_pred_taken); end
        clk_step();
        set_ex(1, 7, 0, 2, 1, 2);
        clk_step();
        set_ex(1, 20, 1, 7, 0, 21);
        clk_step();
        clear_ex();
        #1;
        n_checks++; if (bus.if_pc !== 6'd7) begin n_errors++; $display("FAIL hyst_pc got %0d exp 7", bus.if_pc); end
        n_checks++; if (bus.if_pred_taken !== 1'b0) begin n_errors++; $display("FAIL hyst_c1 got %b exp 0", bus.if_pred_taken); end
        n_checks++; if (bus.if_pred_target !== 6'd2) begin n_errors++; $display("FAIL hyst_c1_tgt got %0d exp 2", bus.if_pred_target); end
    endtask

    task automatic test_alias_target();
        do_reset();
        set_ex(1, 1, 1, 9, 0, 2);
        clk_step();
        set_ex(1, 5, 1, 12, 0, 6);
        clk_step();
        set_ex(1, 30, 1, 1, 0, 31);
        clk_step();
        clear_ex();
        #1;
        n_checks++; if (bus.if_pc !== 6'd1) begin n_errors++; $display("FAIL alias_pc got %0d exp 1", bus.if_pc); end
        n_checks++; if (bus.if_pred_taken !== 1'b0) begin n_errors++; $display("FAIL alias_pred got %b exp 0", bus.if_pred_taken); end
        n_checks++; if (bus.if_pred_target !== 6'd2) begin n_errors++; $display("FAIL alias_tgt got %0d exp 2", bus.if_pred_target); end
        clk_step();
        set_ex(1, 5, 1, 20, 1, 12);
        #1;
        n_checks++; if (bus.flush !== 1'b1) begin n_errors++; $display("FAIL tgtmis_flush got %b exp 1", bus.flush); end
        clk_step();
        clear_ex();
        n_checks++; if (bus.if_pc !== 6'd20) begin n_errors++; $display("FAIL tgtmis_pc got %0d exp 20", bus.if_pc); end
        set_ex(1, 40, 1, 5, 0, 41);
        clk_step();
        // Update the line being looked up in the same cycle: lookup sees old.
        set_ex(1, 5, 1, 25, 1, 20);
        #1;
        n_checks++; if (bus.if_pred_target !== 6'd20) begin n_errors++; $display("FAIL rd_old_tgt got %0d exp 20", bus.if_pred_target); end
        n_checks++; if (bus.if_pred_taken !== 1'b1) begin n_errors++; $display("FAIL rd_old_pred got %b exp 1", bus.if_pred_taken); end
        clk_step();
        n_checks++; if (bus.if_pc !== 6'd25) begin n_errors++; $display("FAIL rd_old_pc got %0d exp 25", bus.if_pc); end
        set_ex(1, 40, 1, 5, 0, 41);
        clk_step();
        clear_ex();
        #1;
        n_checks++; if (bus.if_pred_target !== 6'd25) begin n_errors++; $display("FAIL rd_new_tgt got %0d exp 25", bus.if_pred_target); end
    endtask

    task automatic test_async_reset();
        do_reset();
        run_to(34);
        set_ex(1, 3, 1, 12, 0, 4);
        clk_step();
        clear_ex();
        n_checks++; if (bus.done !== 1'b1) begin n_errors++; $display("FAIL done_held got %b exp 1", bus.done); end
        clk_step();
        n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL done_clear got %b exp 0", bus.done); end
        set_ex(1, 3, 1, 12, 1, 11);
        clk_step();
        clear_ex();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.if_pc !== 6'd0) begin n_errors++; $display("FAIL async_pc got %0d exp 0", bus.if_pc); end
        n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL async_done got %b exp 0", bus.done); end
        model_reset();
        rst_n = 1'b1;
        run_to(3);
        #1;
        n_checks++; if (bus.if_pred_taken !== 1'b0) begin n_errors++; $display("FAIL async_btb_pred got %b exp 0", bus.if_pred_taken); end
        n_checks++; if (bus.if_pred_target !== 6'd4) begin n_errors++; $display("FAIL async_btb_tgt got %0d exp 4", bus.if_pred_target); end
    endtask

    task automatic test_btb_disabled();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            n_checks++; if (bus0.if_pred_taken !== 1'b0) begin n_errors++; $display("FAIL dis_pred_run got %b exp 0", bus0.if_pred_taken); end
            clk_step();
        end
        for (int r = 0; r < 3; r++) begin
            n_checks++; if (bus0.if_pc !== 6'd7) begin n_errors++; $display("FAIL dis_pc7 got %0d exp 7", bus0.if_pc); end
            set_ex0(1, 7, 1, 2, 0, 8);
            #1;
            n_checks++; if (bus0.flush !== 1'b1) begin n_errors++; $display("FAIL dis_flush got %b exp 1", bus0.flush); end
            n_checks++; if (bus0.if_pred_taken !== 1'b0) begin n_errors++; $display("FAIL dis_pred got %b exp 0", bus0.if_pred_taken); end
            clk_step();
            set_ex0(0, 0, 0, 0, 0, 0);
            n_checks++; if (bus0.if_pc !== 6'd2) begin n_errors++; $display("FAIL dis_redir got %0d exp 2", bus0.if_pc); end
            for (int k = 0; k < 5; k++) begin
                n_checks++; if (bus0.if_pred_taken !== 1'b0) begin n_errors++; $display("FAIL dis_pred_loop got %b exp 0", bus0.if_pred_taken); end
                clk_step();
            end
        end
    endtask

    task automatic test_random();
        int xpc, tgt;
        bit tk, ptk, mp;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bus.stall = ($urandom_range(0, 99) < 15);
            xpc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 15);
            tk  = $urandom_range(0, 1);
            tgt = ($urandom_range(0, 3) == 0) ? $urandom_range(32, 63) : $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                ptk = m_pred_t(xpc);
                set_ex($urandom_range(0, 99) < 35, xpc, tk, tgt, ptk, m_pred_tgt(xpc));
            end else begin
                ptk = $urandom_range(0, 1);
                set_ex($urandom_range(0, 99) < 35, xpc, tk, tgt, ptk,
                       ($urandom_range(0, 1) == 1) ? tgt : $urandom_range(0, 63));
            end
            #1;
            mp = m_misp();
            n_checks++; if (bus.if_pc !== 6'(m_pc)) begin n_errors++; $display("FAIL rnd_pc c%0d got %0d exp %0d", c, bus.if_pc, m_pc); end
            n_checks++; if (bus.imem_addr !== 5'(m_pc % 32)) begin n_errors++; $display("FAIL rnd_addr c%0d got %0d exp %0d", c, bus.imem_addr, m_pc % 32); end
            n_checks++; if (bus.if_pred_taken !== m_pred_t(m_pc)) begin n_errors++; $display("FAIL rnd_pred c%0d got %b exp %b", c, bus.if_pred_taken, m_pred_t(m_pc)); end
            n_checks++; if (bus.if_pred_target !== 6'(m_pred_tgt(m_pc))) begin n_errors++; $display("FAIL rnd_tgt c%0d got %0d exp %0d", c, bus.if_pred_target, m_pred_tgt(m_pc)); end
            n_checks++; if (bus.flush !== mp) begin n_errors++; $display("FAIL rnd_flush c%0d got %b exp %b", c, bus.flush, mp); end
            n_checks++; if (bus.done !== m_done) begin n_errors++; $display("FAIL rnd_done c%0d got %b exp %b", c, bus.done, m_done); end
            clk_step();
        end
        clear_ex();
        bus.stall = 1'b0;
    endtask

    initial begin
        model_reset();
        clear_ex();
        test_reset();
        test_straight_line();
        test_stall_redirect();
        test_cold_learn();
        test_hysteresis();
        test_alias_target();
        test_async_reset();
        test_btb_disabled();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
